// File: rtl/fuzzy_pkg.sv
// Shared fixed-point types and state encodings for the fuzzy
// pipeline (fuzzifiers, rule evaluation, defuzzifier).
package fuzzy_pkg;

    typedef logic [15:0]        q15_t;
    typedef logic signed [7:0]  q7_t;

    localparam q15_t Q15_ONE = 16'h7FFF;

    typedef enum logic [1:0] {
        ACC,
        DIV,
        OUT
    } defuzz_state_t;

endpackage

// File: rtl/seq_udiv.sv
// Sequential unsigned restoring divider, one quotient bit per
// cycle, MSB first; the start cycle already resolves the MSB.
module seq_udiv #(
    parameter int W_N = 28,
    parameter int W_D = 20,
    parameter int W_Q = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W_N-1:0] dividend,
    input  logic [W_D-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [W_Q-1:0] quotient
);

    localparam int W_C = $clog2(W_Q + 1);

    logic [W_N-1:0] rem_q, rem_d;
    logic [W_N-1:0] dsh_q, dsh_d;
    logic [W_Q-1:0] quo_q, quo_d;
    logic [W_C-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W_N-1:0] rem_in;
    logic [W_N-1:0] dsh_in;
    logic [W_Q-1:0] quo_in;
    logic [W_N-1:0] div_ext;
    logic           ge;

    always_comb begin
        div_ext = {{(W_N - W_D){1'b0}}, divisor};
        rem_in  = start ? dividend : rem_q;
        dsh_in  = start ? (div_ext << (W_Q - 1)) : dsh_q;
        quo_in  = start ? '0 : quo_q;
        ge      = (rem_in >= dsh_in);

        rem_d  = rem_q;
        dsh_d  = dsh_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            rem_d  = ge ? (rem_in - dsh_in) : rem_in;
            dsh_d  = dsh_in >> 1;
            quo_d  = {quo_in[W_Q-2:0], ge};
            cnt_d  = start ? W_C'(1) : cnt_q + W_C'(1);
            busy_d = (cnt_d != W_C'(W_Q));
            done_d = !busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsh_q  <= dsh_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/defuzz_wavg.sv
// Sugeno weighted-average defuzzifier: accumulates mu and mu*s
// over a frame, then divides with fixed latency.
module defuzz_wavg
    import fuzzy_pkg::*;
#(
    parameter int N_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_mu,
    input  logic signed [7:0] in_s,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] out_y,
    output logic              out_zero,
    output logic              out_ovf
);

    localparam int W_SUMW  = 16 + $clog2(N_MAX);
    localparam int W_SUMWS = W_SUMW + 8;
    localparam int W_CNT   = $clog2(N_MAX + 1);

    defuzz_state_t state_q, state_d;

    logic [W_SUMW-1:0]         sum_w_q, sum_w_d;
    logic signed [W_SUMWS-1:0] sum_ws_q, sum_ws_d;
    logic [W_CNT-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      start_q, start_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_zero_q, out_zero_d;
    logic                      out_ovf_q, out_ovf_d;
    q7_t                       out_y_q, out_y_d;

    q15_t                      mu_c;
    logic signed [16:0]        mu_s;
    logic signed [24:0]        prod;
    logic [W_SUMWS-1:0]        mag;
    logic signed [8:0]         q_s;
    logic [7:0]                quo;
    logic                      div_busy;
    logic                      div_done;

    seq_udiv #(
        .W_N (W_SUMWS),
        .W_D (W_SUMW),
        .W_Q (8)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .dividend (mag),
        .divisor  (sum_w_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    always_comb begin
        mu_c = (in_mu > Q15_ONE) ? Q15_ONE : in_mu;
        mu_s = signed'({1'b0, mu_c});
        prod = 25'(mu_s) * 25'(in_s);
        mag  = sum_ws_q[W_SUMWS-1] ? unsigned'(-sum_ws_q)
                                   : unsigned'(sum_ws_q);
        q_s  = sum_ws_q[W_SUMWS-1] ? -signed'({1'b0, quo})
                                   : signed'({1'b0, quo});

        state_d     = state_q;
        sum_w_d     = sum_w_q;
        sum_ws_d    = sum_ws_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        start_d     = 1'b0;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_y_d     = out_y_q;

        unique case (state_q)
            ACC: begin
                if (in_valid && in_ready_q) begin
                    if (cnt_q == W_CNT'(N_MAX)) begin
                        ovf_d = 1'b1;
                    end else begin
                        sum_w_d  = sum_w_q + W_SUMW'(mu_c);
                        sum_ws_d = sum_ws_q + W_SUMWS'(prod);
                        cnt_d    = cnt_q + W_CNT'(1);
                    end
                    if (in_last) begin
                        state_d    = DIV;
                        in_ready_d = 1'b0;
                        start_d    = 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done && !div_busy) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_ovf_d   = ovf_q;
                    // zero weight: quotient is meaningless, force 0
                    if (sum_w_q == '0) begin
                        out_y_d    = '0;
                        out_zero_d = 1'b1;
                    end else if (q_s > 9'sd127) begin
                        out_y_d = 8'sd127;
                    end else if (q_s < -9'sd128) begin
                        out_y_d = -8'sd128;
                    end else begin
                        out_y_d = q_s[7:0];
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d     = ACC;
                    sum_w_d     = '0;
                    sum_ws_d    = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_zero_d  = 1'b0;
                    out_ovf_d   = 1'b0;
                    out_y_d     = '0;
                end
            end
            default: begin
                state_d    = ACC;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            sum_w_q     <= '0;
            sum_ws_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            sum_w_q     <= sum_w_d;
            sum_ws_q    <= sum_ws_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            start_q     <= start_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_y_q     <= out_y_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_defuzz_wavg.sv
// Scoreboard bench for defuzz_wavg: a reference model queues the
// expected result per frame, the collector pops and compares.
module tb_defuzz_wavg;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_mu = '0;
    logic signed [7:0] in_s = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_y;
    logic              out_zero;
    logic              out_ovf;

    typedef struct {
        byte y;
        bit  zero;
        bit  ovf;
    } exp_t;

    exp_t sb[$];
    int   fm_mu[$];
    int   fm_s[$];
    int   n_checks = 0;
    int   n_errors = 0;

    defuzz_wavg #(.N_MAX(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mu     (in_mu),
        .in_s      (in_s),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input int mu, input int s);
        fm_mu.push_back(mu);
        fm_s.push_back(s);
    endtask

    task automatic send_beat(input int mu, input int s, input bit last);
        int n;
        in_valid = 1'b1;
        in_mu    = 16'(mu);
        in_s     = 8'(s);
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int hold);
        int   k;
        exp_t e;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk("out_timeout", 0, 1);
            return;
        end
        chk("latency", k, 9);
        chk("y", out_y, e.y);
        chk("zero", out_zero, e.zero);
        chk("ovf", out_ovf, e.ovf);
        chk("in_ready_out", in_ready, 0);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_mu    = 16'h7FFF;
            in_s     = 8'sd100;
            in_last  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_valid", out_valid, 1);
                chk("bp_y", out_y, e.y);
                chk("bp_zero", out_zero, e.zero);
                chk("bp_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
    endtask

    task automatic run_frame(input int hold);
        longint sw, sws, q, m;
        exp_t   e;
        sw  = 0;
        sws = 0;
        for (int i = 0; i < fm_mu.size(); i++) begin
            m = (fm_mu[i] > 32767) ? 32767 : fm_mu[i];
            if (i < 16) begin
                sw  += m;
                sws += m * fm_s[i];
            end
        end
        e.ovf = (fm_mu.size() > 16);
        if (sw == 0) begin
            e.y    = 0;
            e.zero = 1'b1;
        end else begin
            q = sws / sw;
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            e.y    = byte'(q);
            e.zero = 1'b0;
        end
        sb.push_back(e);
        for (int i = 0; i < fm_mu.size(); i++)
            send_beat(fm_mu[i], fm_s[i], i == fm_mu.size() - 1);
        collect(hold);
        fm_mu.delete();
        fm_s.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        add(32'h7FFF, -50);
        run_frame(0);

        add(32'h7FFF, 100);
        add(32'h7FFF, -20);
        run_frame(0);

        add(32'h4000, 10);
        add(32'h2000, -70);
        run_frame(0);

        add(0, 20);
        add(0, -90);
        add(0, 5);
        run_frame(0);

        add(32'hFFFF, 5);
        run_frame(0);

        add(32'h7FFF, -128);
        run_frame(5);

        add(32'h1234, 127);
        add(32'h0F00, 127);
        run_frame(0);

        send_beat(32'h7FFF, 60, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_y", out_y, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("mid_rst_no_out", seen, 0);

        add(32'h7FFF, 7);
        run_frame(0);

        for (int i = 0; i < 17; i++) add(32'h7FFF, 3);
        run_frame(0);

        add(32'h3000, 1);
        add(32'h0100, -128);
        add(32'h2000, 50);
        run_frame(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/defuzz_wavg.md
Name: defuzz_wavg

Overview:
Sugeno-style weighted-average defuzzifier. It is the output end of the fuzzy pipeline and the inverse direction of the membership-function fuzzifiers: it consumes a frame of rule firing strengths (Q1.15) paired with output singletons (Q7.0) and produces one crisp Q7.0 value. Rule pairs stream in over a valid/ready handshake. The result leaves over a second valid/ready handshake after a fixed-latency sequential division.

Parameters:
N_MAX, 16, maximum rule beats per frame; sizes the accumulators and the beat counter.
W_SUMW, 16+$clog2(N_MAX), width of the unsigned weight accumulator (derived, localparam).
W_SUMWS, W_SUMW+8, width of the signed weighted-sum accumulator (derived, localparam).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  rule beat valid
in_ready  out  1  block accepts a beat
in_mu  in  16  firing strength, unsigned Q1.15
in_s  in  8  singleton position, signed Q7.0
in_last  in  1  final beat of frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  8  crisp output, signed Q7.0
out_zero  out  1  frame total weight was 0
out_ovf  out  1  frame exceeded N_MAX beats

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low, and sampled on the rising edge of clk.
- Reset state: ACC; accumulators, beat counter and flags cleared; in_ready=1, out_valid=0, out_y=0, out_zero=0, out_ovf=0.
- FSM states:
  - ACC: in_ready=1. A beat is accepted on in_valid & in_ready.
  - DIV: exactly 8 cycles; in_ready=0.
  - OUT: out_valid=1; in_ready=0.
- ACC beat handling:
  - in_mu > 0x7FFF is clamped to 0x7FFF.
  - sum_w += mu.
  - sum_ws += mu * in_s (signed product; mu zero-extended).
  - Beats beyond N_MAX are accepted and dropped; each sets sticky ovf.
  - An accepted beat with in_last moves the FSM to DIV.
- DIV:
  - Compute |sum_ws| / sum_w as an unsigned restoring division, one quotient bit per cycle, MSB first, 8 quotient bits. The quotient magnitude is always ≤128.
  - Apply the sign of sum_ws; the result truncates toward zero.
  - If sum_w==0: skip the division result and force y=0, zero=1. The FSM still spends the full 8 DIV cycles, so latency stays fixed.
  - Clamp the final value to [-128,127].
- Latency: with the accepting edge of the in_last beat at edge t, out_valid is 1 after edge t+9.
- OUT:
  - out_y, out_zero and out_ovf stay stable while out_valid=1 & !out_ready.
  - On out_valid & out_ready: clear the accumulators, counter and flags, and go to ACC. in_ready=1 from the next cycle.
  - There is no overlap: a new frame is not accepted while DIV or OUT is active.
- Reset asserted in any state returns the block to the reset state on that edge. A partial frame is discarded and no out_valid is produced for it.
- A single-beat frame (first beat carries in_last) is legal.
- in_valid is ignored outside ACC.

Decomposition:
- Shared package fuzzy_pkg:
  - q15_t (logic [15:0]) and q7_t (logic signed [7:0]).
  - Constant Q15_ONE = 16'h7FFF.
  - State enum defuzz_state_t {ACC, DIV, OUT}.
  - These types are shared with the fuzzifier and rule-evaluation blocks.
- One sub-module, seq_udiv:
  - Parameterised sequential unsigned restoring divider.
  - Interface: start/busy/done, dividend W_SUMWS, divisor W_SUMW, 8-bit quotient.
  - defuzz_wavg keeps the FSM, accumulation, sign handling and handshakes.

Test Plan:
- Single beat mu=0x7FFF, s=-50, in_last=1 -> out_y=-50 (0xCE), out_zero=0, out_ovf=0; out_valid rises exactly 9 edges after acceptance.
- Two beats (0x7FFF, 100) and (0x7FFF, -20, last) -> out_y=40.
- Two beats (0x4000, 10) and (0x2000, -70, last) -> (163840-573440)/24576 = -16.67 -> out_y=-16 (truncation toward zero).
- Three beats, all mu=0 -> out_y=0, out_zero=1. Also: in_mu=0xFFFF, s=5 alone -> clamped, out_y=5.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; a beat driven with in_valid=1 meanwhile is not accepted. After the handshake, in_ready=1 on the next cycle.
- rst_n=0 for one cycle during DIV -> out_valid stays 0 and the next frame (0x7FFF, 7, last) gives out_y=7. Separately, N_MAX+1 beats all (0x7FFF, 3) -> out_y=3, out_ovf=1.
